// File: rtl/neural_act_pipe.sv
// Float32 activation (PLAN sigmoid, tanh under NEURAL_ACT_TANH_EN): 3 register stages then a DEPTH-entry output FIFO.
// Accept-to-FIFO latency 3 edges; in_ready is a register-only credit check, so consumer stalls never reach the pipeline.

module neural_act_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_vld,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop_vld,
   output logic [W-1:0]           head_dat,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   // DEPTH is a power of two, so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_vld);
      rd_ptr_d = rd_ptr_q + AW'(pop_vld);
      count_d  = count_q + (AW+1)'(push_vld) - (AW+1)'(pop_vld);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld) mem_q[wr_ptr_q] <= push_dat;
   end

   assign head_dat = mem_q[rd_ptr_q];
   assign count    = count_q;
endmodule

module neural_act_pipe #(
   parameter int FRAC_BITS = 16,
   parameter int DEPTH     = 4,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_sat
);
   localparam int          FW      = 32 + TAG_W + 1;
   localparam int          CW      = $clog2(DEPTH) + 2;
   localparam logic [8:0]  SH_BASE = 9'(150 - FRAC_BITS);
   localparam logic [8:0]  SAT_EXP = 9'(158 - FRAC_BITS);
   localparam logic [31:0] ONE     = 32'd1 << FRAC_BITS;
   localparam logic [31:0] X_5     = 32'd5 << FRAC_BITS;
   localparam logic [31:0] X_2P375 = 32'd19 << (FRAC_BITS - 3);
   localparam logic [31:0] C_HI    = 32'd27 << (FRAC_BITS - 5);
   localparam logic [31:0] C_MID   = 32'd5 << (FRAC_BITS - 3);
   localparam logic [31:0] C_LO    = 32'd1 << (FRAC_BITS - 1);

   logic             accept;
   logic [8:0]       e_eff, lsh, rsh;
   logic [31:0]      wide;
   logic             v1_q, v1_d, sign1_q, sign1_d, sat1_q, sat1_d, nan1_q, nan1_d;
   logic [30:0]      mag1_q, mag1_d;
   logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
   logic             v2_q, v2_d, sat2_q, sat2_d, nan2_q, nan2_d;
   logic [31:0]      a, sig, y2_q, y2_d;
   logic             v3_q, v3_d, sat3_q, sat3_d;
   logic [31:0]      f3_q, f3_d, absv, norm;
   logic             neg;
   logic [4:0]       lead;
   logic [FW-1:0]    head;
   logic [$clog2(DEPTH):0] fifo_count;
   logic [CW-1:0]    occupancy;
   logic             fifo_pop;
   logic [9:0]       unused_bits;

   assign occupancy = CW'(fifo_count) + CW'(v1_q) + CW'(v2_q) + CW'(v3_q);
   assign in_ready  = occupancy < CW'(DEPTH);
   assign accept    = in_valid && in_ready;

`ifdef NEURAL_ACT_TANH_EN
   logic mode1_q, mode1_d;
   // tanh(x) = 2*sigmoid(2x) - 1: doubling is an exponent increment.
   assign e_eff   = {1'b0, in_data[30:23]} + {8'd0, in_mode};
   assign mode1_d = in_mode;
`else
   logic unused_mode;
   assign unused_mode = in_mode;
   assign e_eff       = {1'b0, in_data[30:23]};
`endif

   always_comb begin
      wide    = '0;
      sat1_d  = 1'b0;
      nan1_d  = 1'b0;
      lsh     = e_eff - SH_BASE;
      rsh     = SH_BASE - e_eff;
      if (in_data[30:23] == 8'hFF) begin
         if (in_data[22:0] != '0) nan1_d = 1'b1;
         else                     sat1_d = 1'b1;
      end else if (in_data[30:23] != 8'h00) begin
         if (e_eff >= SAT_EXP)      sat1_d = 1'b1;
         else if (e_eff >= SH_BASE) wide = {8'd0, 1'b1, in_data[22:0]} << lsh;
         else if (rsh < 9'd24)      wide = {8'd0, 1'b1, in_data[22:0]} >> rsh;
      end
      mag1_d  = sat1_d ? '1 : wide[30:0];
      v1_d    = accept;
      sign1_d = in_data[31];
      tag1_d  = in_tag;
   end

   always_comb begin
      a = {1'b0, mag1_q};
      if (a >= X_5)          sig = ONE;
      else if (a >= X_2P375) sig = (a >> 5) + C_HI;
      else if (a >= ONE)     sig = (a >> 3) + C_MID;
      else                   sig = (a >> 2) + C_LO;
      if (sign1_q) sig = ONE - sig;
      y2_d = sig;
`ifdef NEURAL_ACT_TANH_EN
      if (mode1_q) y2_d = (sig << 1) - ONE;
`endif
      v2_d   = v1_q;
      sat2_d = sat1_q;
      nan2_d = nan1_q;
      tag2_d = tag1_q;
   end

   always_comb begin
      neg  = y2_q[31];
      absv = neg ? (~y2_q + 32'd1) : y2_q;
      lead = '0;
      for (int i = 0; i < 32; i++) begin
         if (absv[i]) lead = 5'(i);
      end
      // Left-justify so the leading one lands in bit 31; mantissa is truncated.
      norm = absv << (5'd31 - lead);
      if (nan2_q)            f3_d = 32'h7FC0_0000;
      else if (absv == '0)   f3_d = '0;
      else                   f3_d = {neg, 8'(lead) + 8'(127 - FRAC_BITS), norm[30:8]};
      v3_d   = v2_q;
      sat3_d = sat2_q;
      tag3_d = tag2_q;
   end

   assign unused_bits = {wide[31], norm[31], norm[7:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q <= 1'b0; sign1_q <= 1'b0; sat1_q <= 1'b0; nan1_q <= 1'b0;
         mag1_q <= '0; tag1_q <= '0;
         v2_q <= 1'b0; y2_q <= '0; sat2_q <= 1'b0; nan2_q <= 1'b0; tag2_q <= '0;
         v3_q <= 1'b0; f3_q <= '0; sat3_q <= 1'b0; tag3_q <= '0;
      end else begin
         v1_q <= v1_d; sign1_q <= sign1_d; sat1_q <= sat1_d; nan1_q <= nan1_d;
         mag1_q <= mag1_d; tag1_q <= tag1_d;
         v2_q <= v2_d; y2_q <= y2_d; sat2_q <= sat2_d; nan2_q <= nan2_d; tag2_q <= tag2_d;
         v3_q <= v3_d; f3_q <= f3_d; sat3_q <= sat3_d; tag3_q <= tag3_d;
      end
   end

`ifdef NEURAL_ACT_TANH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mode1_q <= 1'b0;
      else        mode1_q <= mode1_d;
   end
`endif

   neural_act_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (v3_q),
      .push_dat ({f3_q, tag3_q, sat3_q}),
      .pop_vld  (fifo_pop),
      .head_dat (head),
      .count    (fifo_count)
   );

   assign out_valid = (fifo_count != '0);
   assign fifo_pop  = out_valid && out_ready;
   // Outputs read as zero whenever the FIFO is empty, including straight after reset.
   assign {out_data, out_tag, out_sat} = out_valid ? head : '0;
endmodule

// File: tb/tb_neural_act_pipe.sv
// Bench for neural_act_pipe: directed tasks driving a scoreboard queue checked by an output monitor.
module tb_neural_act_pipe;
   localparam int TAG_W = 4;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_data = '0;
   logic             in_mode = 1'b0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_sat;

   typedef struct packed {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      logic             sat;
      logic             chk_lat;
      logic [31:0]      acc_edge;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;
   int   pops = 0;
   int   cyc = 0;
   bit   rand_rdy = 1'b0;

   logic [31:0] tab_in  [8] = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h40C0_0000,
                                32'h4040_0000, 32'hC040_0000, 32'h7FC0_0001, 32'h7F80_0000};
   logic [31:0] tab_out [8] = '{32'h3F00_0000, 32'h3F40_0000, 32'h3E80_0000, 32'h3F80_0000,
                                32'h3F70_0000, 32'h3D80_0000, 32'h7FC0_0000, 32'h3F80_0000};
   logic        tab_sat [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   neural_act_pipe #(.FRAC_BITS(16), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .out_sat(out_sat)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   initial forever begin
      @(negedge clk);
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   // Output monitor: sampled just before the rising edge that completes a transfer.
   initial forever begin
      @(negedge clk);
      #4;
      if (out_valid && out_ready) begin
         pops++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got data=%h tag=%h sat=%b, none expected", out_data, out_tag, out_sat);
         end else begin
            mon_e = sb.pop_front();
            if ({out_data, out_tag, out_sat} !== {mon_e.data, mon_e.tag, mon_e.sat}) begin
               errors++;
               $display("FAIL output got data=%h tag=%h sat=%b expected data=%h tag=%h sat=%b",
                        out_data, out_tag, out_sat, mon_e.data, mon_e.tag, mon_e.sat);
            end
            if (mon_e.chk_lat) begin
               checks++;
               if ((cyc + 1 - int'(mon_e.acc_edge)) != 4) begin
                  errors++;
                  $display("FAIL latency tag=%h got pop %0d edges after accept, expected 4",
                           mon_e.tag, cyc + 1 - int'(mon_e.acc_edge));
               end
            end
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic m, input logic [TAG_W-1:0] t,
                       input logic [31:0] ed, input logic es, input logic lat);
      int   w;
      exp_t e;
      w = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
      #1;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_timeout tag=%h got in_ready=%b expected 1", t, in_ready);
      end else begin
         e = '{data: ed, tag: t, sat: es, chk_lat: lat, acc_edge: 32'(cyc + 1)};
         sb.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int w;
      w = 0;
      while ((sb.size() != 0 || out_valid) && w < 400) begin
         @(negedge clk);
         w++;
      end
      repeat (6) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d results outstanding, expected 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      #2;
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h expected 0", out_data); end
      if (out_tag !== '0)     begin errors++; $display("FAIL reset_out_tag got %h expected 0", out_tag); end
      if (out_sat !== 1'b0)   begin errors++; $display("FAIL reset_out_sat got %b expected 0", out_sat); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks += 2;
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready got %b expected 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b expected 0", out_valid); end
   endtask

   task automatic test_sigmoid();
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(tab_in[i], 1'b0, 4'(i + 1), tab_out[i], tab_sat[i], 1'b1);
      send(32'hC0C0_0000, 1'b0, 4'd5, 32'h0000_0000, 1'b0, 1'b1);
      idle();
      wait_drain("sigmoid");
   endtask

   task automatic test_tanh();
`ifdef NEURAL_ACT_TANH_EN
      send(32'h0000_0000, 1'b1, 4'hA, 32'h0000_0000, 1'b0, 1'b0);
      send(32'h3F80_0000, 1'b1, 4'hB, 32'h3F40_0000, 1'b0, 1'b0);
      send(32'hBF80_0000, 1'b1, 4'hC, 32'hBF40_0000, 1'b0, 1'b0);
      send(32'h4040_0000, 1'b1, 4'hD, 32'h3F80_0000, 1'b0, 1'b0);
`else
      send(32'h0000_0000, 1'b1, 4'hA, 32'h3F00_0000, 1'b0, 1'b0);
      send(32'h3F80_0000, 1'b1, 4'hB, 32'h3F40_0000, 1'b0, 1'b0);
      send(32'hBF80_0000, 1'b1, 4'hC, 32'h3E80_0000, 1'b0, 1'b0);
      send(32'h4040_0000, 1'b1, 4'hD, 32'h3F70_0000, 1'b0, 1'b0);
`endif
      idle();
      wait_drain("tanh");
   endtask

   task automatic test_specials();
      send(32'h7F80_0000, 1'b0, 4'h1, 32'h3F80_0000, 1'b1, 1'b0);
      send(32'hFF80_0000, 1'b0, 4'h2, 32'h0000_0000, 1'b1, 1'b0);
      send(32'h7FC0_0001, 1'b0, 4'h3, 32'h7FC0_0000, 1'b0, 1'b0);
      send(32'h0000_0001, 1'b0, 4'h4, 32'h3F00_0000, 1'b0, 1'b0);
      send(32'h4700_0000, 1'b0, 4'h5, 32'h3F80_0000, 1'b1, 1'b0);
      send(32'h46FF_FE00, 1'b0, 4'h6, 32'h3F80_0000, 1'b0, 1'b0);
      send(32'h471C_4000, 1'b0, 4'h7, 32'h3F80_0000, 1'b1, 1'b0);
      send(32'h4018_0000, 1'b0, 4'h8, 32'h3F6B_0000, 1'b0, 1'b0);
      send(32'h40A0_0000, 1'b0, 4'h9, 32'h3F80_0000, 1'b0, 1'b0);
      send(32'h3F00_0000, 1'b0, 4'hA, 32'h3F20_0000, 1'b0, 1'b0);
      send(32'h4000_0000, 1'b0, 4'hB, 32'h3F60_0000, 1'b0, 1'b0);
      idle();
      wait_drain("specials");
   endtask

   task automatic test_backpressure();
      int   acc;
      exp_t e;
      acc = 0;
      @(negedge clk);
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         in_valid = 1'b1; in_mode = 1'b0;
         in_data = tab_in[(acc + 1) % 8];
         in_tag  = 4'(8 + acc);
         #1;
         if (in_ready) begin
            e = '{data: tab_out[(acc + 1) % 8], tag: 4'(8 + acc), sat: tab_sat[(acc + 1) % 8],
                  chk_lat: 1'b0, acc_edge: 32'(cyc + 1)};
            sb.push_back(e);
            acc++;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      checks += 3;
      if (acc != DEPTH)      begin errors++; $display("FAIL bp_accepts got %0d expected %0d", acc, DEPTH); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full got %b expected 0", in_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b expected 1", out_valid); end
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after_pop got %b expected 1", in_ready); end
      wait_drain("backpressure");
   endtask

   task automatic test_back_to_back();
      int p0;
      int k;
      p0 = pops;
      rand_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         k = $urandom_range(0, 7);
         send(tab_in[k], 1'b0, 4'(i), tab_out[k], tab_sat[k], 1'b0);
      end
      idle();
      wait_drain("back_to_back");
      rand_rdy = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (pops - p0 != 20) begin errors++; $display("FAIL b2b_count got %0d pops expected 20", pops - p0); end
   endtask

   task automatic test_reset_mid();
      int p0;
      @(negedge clk);
      out_ready = 1'b0;
      send(tab_in[1], 1'b0, 4'h1, tab_out[1], 1'b0, 1'b0);
      send(tab_in[2], 1'b0, 4'h2, tab_out[2], 1'b0, 1'b0);
      idle();
      repeat (5) @(negedge clk);
      send(tab_in[3], 1'b0, 4'h3, tab_out[3], 1'b0, 1'b0);
      send(tab_in[4], 1'b0, 4'h4, tab_out[4], 1'b0, 1'b0);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid got %b expected 0", out_valid); end
      if (out_data !== 32'h0) begin errors++; $display("FAIL mid_reset_out_data got %h expected 0", out_data); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_reset_in_ready got %b expected 1", in_ready); end
      sb.delete();
      p0 = pops;
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      checks += 3;
      if (pops != p0)         begin errors++; $display("FAIL mid_reset_stale got %0d outputs expected 0", pops - p0); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_idle_valid got %b expected 0", out_valid); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_reset_idle_ready got %b expected 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_sigmoid();
      test_tanh();
      test_specials();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
